// File: rtl/enflop_pipe.sv
// Elastic register chain that permutes incoming words, carries a per-bit output
// enable alongside each word, and masks disabled bits with FILL at the head.
module enflop_pipe #(
  parameter int              WIDTH  = 8,
  parameter int              STAGES = 2,
  parameter int              MODE   = 0,
  parameter logic [WIDTH-1:0] FILL  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic [WIDTH-1:0]             oe,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(STAGES+1)-1:0]  count
);

  localparam int CNT_W = $clog2(STAGES+1);

  logic [STAGES-1:0] vld_p;
  logic [WIDTH-1:0]  data_p [STAGES];
  logic [WIDTH-1:0]  oe_p   [STAGES];

  logic [STAGES-1:0] take;
  logic [STAGES-1:0] src_vld;
  logic [WIDTH-1:0]  src_data [STAGES];
  logic [WIDTH-1:0]  src_oe   [STAGES];

  function automatic logic [WIDTH-1:0] permute(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    int j;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (MODE == 0) begin
        j = WIDTH - 1 - i;
      end else if (MODE == 1) begin
        j = i ^ 1;
        // Odd width: the unpaired top bit stays in place.
        if (j >= WIDTH) j = i;
      end else begin
        j = i;
      end
      r[i] = d[j];
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] mask_fill(input logic [WIDTH-1:0] d,
                                                 input logic [WIDTH-1:0] en);
    return (d & en) | (FILL & ~en);
  endfunction

  // Ready ripples back from the output: a stage takes a new entry when it is
  // empty or its occupant moves on this cycle, so bubbles collapse under stall.
  always_comb begin
    logic down_rdy;
    down_rdy = out_ready;
    take     = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      take[k]  = !vld_p[k] || down_rdy;
      down_rdy = take[k];
    end
  end

  always_comb begin
    src_vld     = '0;
    src_vld[0]  = in_valid;
    src_data[0] = permute(in_data);
    src_oe[0]   = oe;
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k]  = vld_p[k-1];
      src_data[k] = data_p[k-1];
      src_oe[k]   = oe_p[k-1];
    end
  end

  assign in_ready = take[0];

  // Stage registers: valid follows the load decision; payload is only
  // captured with a real word so an idle head keeps presenting FILL after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_p[k] <= '0;
        oe_p[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (take[k]) begin
          vld_p[k] <= src_vld[k];
          if (src_vld[k]) begin
            data_p[k] <= src_data[k];
            oe_p[k]   <= src_oe[k];
          end
        end
      end
    end
  end

  // Output stage: combinational view of the head registers only.
  always_comb begin
    count = '0;
    for (int k = 0; k < STAGES; k++) begin
      count = count + CNT_W'(vld_p[k]);
    end
  end

  assign out_valid = vld_p[STAGES-1];
  assign out_data  = mask_fill(data_p[STAGES-1], oe_p[STAGES-1]);

endmodule

// File: doc/enflop_pipe.md
ENFLOP_PIPE -- requirements
Module: enflop_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; legal range 1..64.
REQ-002 Parameter STAGES, default 2, pipeline depth in register stages; legal range 1..8.
REQ-003 Parameter MODE, default 0, bit permutation: 0 = reverse (out[i] = in[WIDTH-1-i]); 1 = pair swap (out[i] = in[i^1]); 2 = identity.
REQ-004 Parameter FILL, default all-zero, WIDTH-bit value driven on output bits whose captured enable is 0.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  upstream word valid.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 in_data  input  WIDTH  upstream word.
REQ-010 oe  input  WIDTH  per-bit output enable, sampled together with in_data.
REQ-011 out_valid  output  1  head word valid.
REQ-012 out_ready  input  1  downstream accepts head word.
REQ-013 out_data  output  WIDTH  head word after permutation and enable masking.
REQ-014 count  output  $clog2(STAGES+1)  number of occupied stages.

Function
REQ-015 The block SHALL be an elastic chain of STAGES registers, each holding a valid bit, WIDTH data bits and WIDTH enable bits.
REQ-016 Transfer SHALL occur on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
REQ-017 Permutation per MODE SHALL be applied to in_data before capture into stage 0; oe bits SHALL be captured unpermuted, aligned to output bit positions.
REQ-018 With MODE=1 and odd WIDTH, bit WIDTH-1 SHALL map to itself.
REQ-019 out_data[i] SHALL equal the head-stage data bit i when its captured enable bit i is 1, otherwise FILL[i]; it is a combinational function of head-stage registers only.
REQ-020 out_valid SHALL equal the valid bit of the last stage.
REQ-021 Stage k SHALL load from stage k-1 (stage 0 from the input) when stage k is empty or stage k is advancing this cycle; it SHALL otherwise hold its data, enables and valid.
REQ-022 in_ready SHALL be 1 when stage 0 is empty or stage 0 is advancing this cycle; ready SHALL ripple combinationally from out_ready so a full, unstalled pipe sustains one word per cycle.
REQ-023 Latency SHALL be exactly STAGES cycles from input transfer to out_valid, absent stalls.
REQ-024 Words SHALL leave in acceptance order; no word SHALL be dropped or duplicated.
REQ-025 A bubble SHALL collapse: an empty stage SHALL be filled even when downstream stages are stalled.
REQ-026 count SHALL equal the number of set valid bits, updating the cycle after each transfer; simultaneous input and output transfer SHALL leave count unchanged.
REQ-027 When count == STAGES and out_ready == 0, in_ready SHALL be 0 and all stage contents SHALL hold.
REQ-028 out_data SHALL NOT change while out_valid && !out_ready.

Reset
REQ-029 When rst is 1 at a rising clk edge, all valid bits, data bits and enable bits SHALL clear to 0, regardless of in_valid or out_ready.
REQ-030 During and after reset: out_valid = 0, count = 0, out_data = FILL (enables cleared), in_ready = 1.
REQ-031 Reset mid-operation SHALL discard all in-flight words; the first word accepted after rst deasserts SHALL be the first word output.

Verification
REQ-032 WIDTH=8, STAGES=2, MODE=0, oe=8'hFF, out_ready=1; accept in_data=8'hED at cycle N -> out_valid=1, out_data=8'hB7 at cycle N+2.
REQ-033 MODE=1, in_data=8'hED, oe=8'hFF -> out_data=8'hDE; MODE=2, in_data=8'hED, oe=8'h0F, FILL=8'h00 -> out_data=8'h0D; same with FILL=8'hA0 -> 8'hAD.
REQ-034 STAGES=2, out_ready=0, push 8'h11, 8'h22 -> count=2, in_ready=0, out_data=8'h11 (MODE=2) held; raise out_ready -> 8'h11 then 8'h22 on consecutive cycles, count returns to 0.
REQ-035 Continuous stream 8'h00..8'h0F with out_ready=1 -> 16 outputs in order, one per cycle, in_ready never 0, count steady at STAGES.
REQ-036 Pipe holding 2 words, assert rst one cycle -> next cycle out_valid=0, count=0, out_data=FILL; subsequent push 8'h5A emerges STAGES cycles later with no stale words.
REQ-037 Random in_valid/out_ready toggling against a reference queue -> zero ordering, loss or duplication mismatches over 10000 cycles.
